regfile_bypass_sb: RTL and testbench
====================================

Name: regfile_bypass_sb

Overview:
- Parametrised successor to the single-write, two-read MIPS register file.
- Adds N configurable read ports, optional write-to-read bypass, and a per-register scoreboard (busy bits plus pending count) so ID can detect load-use and long-latency hazards.
- Sits in the ID stage: read ports feed ID/EX, the write port is driven from MEM/WB, and the reservation port is driven by ID when it issues an instruction whose result arrives late.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero: never written, never reserved.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active high.
- wr_en  in  1  write strobe, sampled at posedge clk.
- wr_addr  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k's register has an outstanding reservation.
- rsv_en  in  1  reserve the destination register, sampled at posedge clk.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_cnt  out  ADDR_W+1  number of registers currently reserved.
- rsv_full  out  1  high when busy_cnt == 2**ADDR_W - ZERO_REG.

Behaviour:
- Reset (rst high, asynchronous): all 2**ADDR_W entries = 0, all busy bits = 0, busy_cnt = 0. Reads are still combinational during reset, so rd_data = 0 and rd_busy = 0.
- Reset is asserted mid-operation: it overrides any write or reservation in that cycle; no partial update.
- Write: at posedge clk with wr_en=1, mem[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: combinational, 0-cycle latency, all ports independent. Any number of ports may read the same address.
  - Port k returns mem[rd_addr_k].
  - If ZERO_REG=1 and rd_addr_k=0, it returns 0.
- Bypass (BYPASS=1): if wr_en=1, wr_addr=rd_addr_k and the write is not dropped, rd_data_k = wr_data in that same cycle.
- BYPASS=0: the new value is visible the cycle after the write edge.
- Scoreboard set: at posedge with rsv_en=1, busy[rsv_addr] <= 1.
  - Ignored when ZERO_REG=1 and rsv_addr=0.
  - Reserving an already-busy register is allowed; the bit stays 1 and busy_cnt does not change.
- Scoreboard clear: at posedge with a non-dropped write, busy[wr_addr] <= 0.
- Simultaneous events at the same posedge:
  - Reservation and write to the same address: the write data is stored and busy ends at 1 (new reservation wins).
  - Reservation and write to different addresses: both take effect.
- busy_cnt: registered, equals the popcount of busy[] after each edge. Per edge it is +1, -1, or 0 (set and clear both effective on different registers, or no net change). It never wraps, and never exceeds 2**ADDR_W - ZERO_REG.
- rd_busy_k: combinational, = busy[rd_addr_k], forced to 0 for a dropped-zero address.
  - With BYPASS=1, it is also forced to 0 when the same-cycle write matches rd_addr_k, because the data is already on rd_data.
  - With BYPASS=0, the bit clears the cycle after the write.
- rsv_full: combinational from busy_cnt. It is a status output only; reservations are still accepted while it is high.
- No internal stall logic. The hazard decision (OR of the relevant rd_busy bits) belongs to the ID control unit.

Test Plan:
- Reset and zero register: assert rst mid-cycle after writing r5=0x1234 → rd_data on all ports = 0, busy_cnt=0. Then write r0=0xFFFF_FFFF → reading r0 returns 0.
- Bypass: wr_en=1, wr_addr=7, wr_data=0xDEAD_BEEF, rd_addr port0=7 in the same cycle → port0 = 0xDEAD_BEEF before the edge. With BYPASS=0 → old value (0) before the edge, 0xDEAD_BEEF after.
- Multi-port: NUM_RD=4, registers r1..r4 = 0x11,0x22,0x33,0x44, rd_addr={4,3,2,1} → rd_data={0x44,0x33,0x22,0x11}. All four ports at r3 → all four read 0x33.
- Scoreboard: rsv r9 → next cycle rd_busy=1 for port reading r9, busy_cnt=1. Write r9=0x55 → rd_busy drops the same cycle (BYPASS=1), busy_cnt=0 after the edge.
- Simultaneous events at one edge:
  - Reserve r9 and write r9=0x66 together → mem[r9]=0x66, busy stays 1, busy_cnt unchanged at 1.
  - Reserve r10 and write r9 together → busy_cnt stays 1, now owned by r10.
- Full: ADDR_W=3, ZERO_REG=1, reserve r1..r7 → busy_cnt=7, rsv_full=1. Re-reserve r3 → busy_cnt stays 7. Reserve r0 → ignored.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
// Parametrised register file: N combinational read ports, optional same-cycle
// write bypass, and a busy-bit scoreboard with a population count for hazard detection.
module regfile_bypass_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       rsv_en,
   input  logic [ADDR_W-1:0]          rsv_addr,
   output logic [ADDR_W:0]            busy_cnt,
   output logic                       rsv_full
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(DEPTH - ZERO_REG);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [ADDR_W:0]   r_busy_cnt;

   logic w_wr_zero;
   logic w_rsv_zero;
   logic w_wr_ok;
   logic w_rsv_ok;
   logic w_set_new;
   logic w_clr_real;

   assign w_wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
   assign w_rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);

   // Gating with rst keeps the bypass path quiet while reset is held.
   assign w_wr_ok  = wr_en && !w_wr_zero && !rst;
   assign w_rsv_ok = rsv_en && !w_rsv_zero && !rst;

   // Count moves only when a bit actually changes; a same-address set overrides the clear.
   assign w_set_new  = w_rsv_ok && !r_busy[rsv_addr];
   assign w_clr_real = w_wr_ok && r_busy[wr_addr] &&
                       !(w_rsv_ok && (rsv_addr == wr_addr));

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_mem[gi] <= '0;
            end else if (w_wr_ok && (wr_addr == ADDR_W'(gi))) begin
               r_mem[gi] <= wr_data;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_busy[gi] <= 1'b0;
            end else if (w_rsv_ok && (rsv_addr == ADDR_W'(gi))) begin
               r_busy[gi] <= 1'b1;
            end else if (w_wr_ok && (wr_addr == ADDR_W'(gi))) begin
               r_busy[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy_cnt <= '0;
      end else begin
         case ({w_set_new, w_clr_real})
            2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
            2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
            default: r_busy_cnt <= r_busy_cnt;
         endcase
      end
   end

   assign busy_cnt = r_busy_cnt;
   assign rsv_full = (r_busy_cnt == MAX_CNT);

   genvar gk;
   generate
      for (gk = 0; gk < NUM_RD; gk++) begin : g_rd
         logic [ADDR_W-1:0] w_raddr;
         logic              w_zero;
         logic              w_hit;

         assign w_raddr = rd_addr[gk*ADDR_W +: ADDR_W];
         assign w_zero  = (ZERO_REG != 0) && (w_raddr == '0);
         assign w_hit   = (BYPASS != 0) && w_wr_ok && (wr_addr == w_raddr);

         assign rd_data[gk*DATA_W +: DATA_W] = w_zero ? '0 :
                                               w_hit  ? wr_data : r_mem[w_raddr];
         assign rd_busy[gk] = !w_zero && !w_hit && r_busy[w_raddr];
      end
   endgenerate

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: a 32x32 4-port bypassing instance checked against an
// array model, plus an 8-entry non-bypassing instance for latency and full-scoreboard cases.
module tb_regfile_bypass_sb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: ADDR_W=5, NUM_RD=4, BYPASS=1
   logic         a_wr_en, a_rsv_en;
   logic [4:0]   a_wr_addr, a_rsv_addr;
   logic [31:0]  a_wr_data;
   logic [19:0]  a_rd_addr;
   logic [127:0] a_rd_data;
   logic [3:0]   a_rd_busy;
   logic [5:0]   a_busy_cnt;
   logic         a_rsv_full;

   // Instance B: ADDR_W=3, NUM_RD=2, BYPASS=0
   logic         b_wr_en, b_rsv_en;
   logic [2:0]   b_wr_addr, b_rsv_addr;
   logic [31:0]  b_wr_data;
   logic [5:0]   b_rd_addr;
   logic [63:0]  b_rd_data;
   logic [1:0]   b_rd_busy;
   logic [3:0]   b_busy_cnt;
   logic         b_rsv_full;

   regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .busy_cnt(a_busy_cnt), .rsv_full(a_rsv_full)
   );

   regfile_bypass_sb #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .busy_cnt(b_busy_cnt), .rsv_full(b_rsv_full)
   );

   int checks = 0;
   int errors = 0;

   // Reference model for instance A
   logic [31:0] ma_mem  [32];
   bit          ma_busy [32];

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         ma_mem[i]  = '0;
         ma_busy[i] = 1'b0;
      end
   endtask

   // Register state after the edge: write clears busy, then a reservation sets it.
   task automatic model_commit();
      if (a_wr_en && a_wr_addr != 0) begin
         ma_mem[a_wr_addr]  = a_wr_data;
         ma_busy[a_wr_addr] = 1'b0;
      end
      if (a_rsv_en && a_rsv_addr != 0) ma_busy[a_rsv_addr] = 1'b1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (a_wr_en && a_wr_addr == a) return a_wr_data;
      return ma_mem[a];
   endfunction

   function automatic bit exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (a_wr_en && a_wr_addr == a) return 1'b0;
      return ma_busy[a];
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      for (int i = 0; i < 32; i++) n += ma_busy[i];
      return n;
   endfunction

   task automatic a_set(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re, input logic [4:0] ra, input logic [19:0] rda);
      @(negedge clk);
      a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
      a_rsv_en = re; a_rsv_addr = ra; a_rd_addr = rda;
      #1;
   endtask

   task automatic a_tick();
      @(posedge clk);
      #1;
      model_commit();
   endtask

   task automatic b_set(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic re, input logic [2:0] ra, input logic [5:0] rda);
      @(negedge clk);
      b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
      b_rsv_en = re; b_rsv_addr = ra; b_rd_addr = rda;
      #1;
   endtask

   task automatic b_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_rsv_en = 0; a_rsv_addr = 0; a_rd_addr = 0;
      b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_rsv_en = 0; b_rsv_addr = 0; b_rd_addr = 0;
      model_reset();
      @(negedge clk); #1;
      checks++;
      if (a_rd_data !== '0 || a_rd_busy !== '0 || a_busy_cnt !== '0 || a_rsv_full !== 1'b0) begin
         errors++;
         $display("FAIL reset_a got data=%h busy=%b cnt=%0d full=%b want all 0",
                  a_rd_data, a_rd_busy, a_busy_cnt, a_rsv_full);
      end
      checks++;
      if (b_rd_data !== '0 || b_busy_cnt !== '0 || b_rsv_full !== 1'b0) begin
         errors++;
         $display("FAIL reset_b got data=%h cnt=%0d full=%b want all 0", b_rd_data, b_busy_cnt, b_rsv_full);
      end
      @(negedge clk);
      rst = 1'b0;

      a_set(1, 5, 32'h1234, 1, 6, {4{5'd5}});
      a_tick();
      a_set(0, 0, 0, 0, 0, {5'd6, 5'd5, 5'd5, 5'd5});
      checks++;
      if (a_rd_data[31:0] !== 32'h1234 || a_rd_busy[3] !== 1'b1 || a_busy_cnt !== 6'd1) begin
         errors++;
         $display("FAIL pre_reset_state got r5=%h busy6=%b cnt=%0d want 1234 1 1",
                  a_rd_data[31:0], a_rd_busy[3], a_busy_cnt);
      end

      // Reset mid-cycle while a write and a reservation are pending.
      a_set(1, 5, 32'h9999, 1, 7, {4{5'd5}});
      #2 rst = 1'b1;
      #1;
      checks++;
      if (a_rd_data !== '0 || a_busy_cnt !== '0 || a_rd_busy !== '0) begin
         errors++;
         $display("FAIL reset_mid got data=%h cnt=%0d busy=%b want 0", a_rd_data, a_busy_cnt, a_rd_busy);
      end
      @(posedge clk); #1;
      checks++;
      if (a_rd_data !== '0 || a_busy_cnt !== '0) begin
         errors++;
         $display("FAIL reset_override got data=%h cnt=%0d want 0", a_rd_data, a_busy_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      a_wr_en = 0; a_rsv_en = 0;
      model_reset();
      #1;
      checks++;
      if (a_rd_data[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL reset_release got r5=%h want 0", a_rd_data[31:0]);
      end

      a_set(1, 0, 32'hFFFF_FFFF, 1, 0, 20'd0);
      checks++;
      if (a_rd_data[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL zero_bypass got %h want 0", a_rd_data[31:0]);
      end
      a_tick();
      a_set(0, 0, 0, 0, 0, 20'd0);
      checks++;
      if (a_rd_data[31:0] !== 32'h0 || a_busy_cnt !== 6'd0) begin
         errors++;
         $display("FAIL zero_reg got r0=%h cnt=%0d want 0 0", a_rd_data[31:0], a_busy_cnt);
      end
   endtask

   task automatic test_bypass();
      a_set(1, 7, 32'hDEAD_BEEF, 0, 0, {15'd0, 5'd7});
      checks++;
      if (a_rd_data[31:0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL bypass_a got %h want deadbeef", a_rd_data[31:0]);
      end
      a_tick();
      a_set(0, 0, 0, 0, 0, 20'd0);

      b_set(1, 7, 32'hDEAD_BEEF, 0, 0, {3'd0, 3'd7});
      checks++;
      if (b_rd_data[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL nobypass_before got %h want 0", b_rd_data[31:0]);
      end
      b_tick();
      b_set(0, 0, 0, 0, 0, {3'd0, 3'd7});
      checks++;
      if (b_rd_data[31:0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL nobypass_after got %h want deadbeef", b_rd_data[31:0]);
      end

      b_set(0, 0, 0, 1, 2, {3'd0, 3'd2});
      b_tick();
      b_set(1, 2, 32'hAB, 0, 0, {3'd0, 3'd2});
      checks++;
      if (b_rd_busy[0] !== 1'b1 || b_rd_data[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL nobypass_busy_hold got busy=%b data=%h want 1 0", b_rd_busy[0], b_rd_data[31:0]);
      end
      b_tick();
      b_set(0, 0, 0, 0, 0, {3'd0, 3'd2});
      checks++;
      if (b_rd_busy[0] !== 1'b0 || b_rd_data[31:0] !== 32'hAB || b_busy_cnt !== 4'd0) begin
         errors++;
         $display("FAIL nobypass_busy_clear got busy=%b data=%h cnt=%0d want 0 ab 0",
                  b_rd_busy[0], b_rd_data[31:0], b_busy_cnt);
      end
   endtask

   task automatic test_multiport();
      for (int i = 1; i <= 4; i++) begin
         a_set(1, 5'(i), 32'(8'h11 * i), 0, 0, 20'd0);
         a_tick();
      end
      a_set(0, 0, 0, 0, 0, {5'd4, 5'd3, 5'd2, 5'd1});
      checks++;
      if (a_rd_data !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
         errors++;
         $display("FAIL multiport_distinct got %h want 44/33/22/11", a_rd_data);
      end
      a_set(0, 0, 0, 0, 0, {4{5'd3}});
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (a_rd_data[k*32 +: 32] !== 32'h33) begin
            errors++;
            $display("FAIL multiport_same port%0d got %h want 33", k, a_rd_data[k*32 +: 32]);
         end
      end
   endtask

   task automatic test_scoreboard();
      a_set(0, 0, 0, 1, 9, {10'd0, 5'd10, 5'd9});
      a_tick();
      a_set(0, 0, 0, 0, 0, {10'd0, 5'd10, 5'd9});
      checks++;
      if (a_rd_busy[1:0] !== 2'b01 || a_busy_cnt !== 6'd1) begin
         errors++;
         $display("FAIL sb_reserve got busy=%b cnt=%0d want 01 1", a_rd_busy[1:0], a_busy_cnt);
      end
      a_set(1, 9, 32'h55, 0, 0, {10'd0, 5'd10, 5'd9});
      checks++;
      if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h55 || a_busy_cnt !== 6'd1) begin
         errors++;
         $display("FAIL sb_write_bypass got busy=%b data=%h cnt=%0d want 0 55 1",
                  a_rd_busy[0], a_rd_data[31:0], a_busy_cnt);
      end
      a_tick();
      a_set(0, 0, 0, 0, 0, {10'd0, 5'd10, 5'd9});
      checks++;
      if (a_busy_cnt !== 6'd0 || a_rd_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL sb_clear got cnt=%0d busy=%b want 0 0", a_busy_cnt, a_rd_busy[0]);
      end

      a_set(0, 0, 0, 1, 9, 20'd0);
      a_tick();
      a_set(1, 9, 32'h66, 1, 9, 20'd0);
      a_tick();
      a_set(0, 0, 0, 0, 0, {10'd0, 5'd10, 5'd9});
      checks++;
      if (a_rd_data[31:0] !== 32'h66 || a_rd_busy[0] !== 1'b1 || a_busy_cnt !== 6'd1) begin
         errors++;
         $display("FAIL sb_same_addr got data=%h busy=%b cnt=%0d want 66 1 1",
                  a_rd_data[31:0], a_rd_busy[0], a_busy_cnt);
      end
      a_set(1, 9, 32'h77, 1, 10, {10'd0, 5'd10, 5'd9});
      a_tick();
      a_set(0, 0, 0, 0, 0, {10'd0, 5'd10, 5'd9});
      checks++;
      if (a_busy_cnt !== 6'd1 || a_rd_busy[1:0] !== 2'b10 || a_rd_data[31:0] !== 32'h77) begin
         errors++;
         $display("FAIL sb_diff_addr got cnt=%0d busy=%b data=%h want 1 10 77",
                  a_busy_cnt, a_rd_busy[1:0], a_rd_data[31:0]);
      end
   endtask

   task automatic test_full();
      for (int i = 1; i <= 7; i++) begin
         b_set(0, 0, 0, 1, 3'(i), 6'd0);
         b_tick();
         if (i == 6) begin
            checks++;
            if (b_busy_cnt !== 4'd6 || b_rsv_full !== 1'b0) begin
               errors++;
               $display("FAIL full_almost got cnt=%0d full=%b want 6 0", b_busy_cnt, b_rsv_full);
            end
         end
      end
      b_set(0, 0, 0, 0, 0, 6'd0);
      checks++;
      if (b_busy_cnt !== 4'd7 || b_rsv_full !== 1'b1) begin
         errors++;
         $display("FAIL full_set got cnt=%0d full=%b want 7 1", b_busy_cnt, b_rsv_full);
      end
      b_set(0, 0, 0, 1, 3, 6'd0);
      b_tick();
      b_set(0, 0, 0, 1, 0, 6'd0);
      b_tick();
      b_set(0, 0, 0, 0, 0, {3'd3, 3'd0});
      checks++;
      if (b_busy_cnt !== 4'd7 || b_rd_busy !== 2'b10) begin
         errors++;
         $display("FAIL full_rereserve got cnt=%0d busy=%b want 7 10", b_busy_cnt, b_rd_busy);
      end
      b_set(1, 3, 32'h3, 0, 0, 6'd0);
      b_tick();
      b_set(0, 0, 0, 0, 0, 6'd0);
      checks++;
      if (b_busy_cnt !== 4'd6 || b_rsv_full !== 1'b0) begin
         errors++;
         $display("FAIL full_release got cnt=%0d full=%b want 6 0", b_busy_cnt, b_rsv_full);
      end
   endtask

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [19:0] rda;
         logic [4:0]  wa;
         int          ec;
         wa = rand_addr();
         for (int k = 0; k < 4; k++) rda[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
         a_set(1'($urandom_range(0, 2) == 0), wa, $urandom,
               1'($urandom_range(0, 1)), rand_addr(), rda);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_rd_data[k*32 +: 32] !== exp_rd(rda[k*5 +: 5]) ||
                a_rd_busy[k] !== exp_busy(rda[k*5 +: 5])) begin
               errors++;
               $display("FAIL rand_port%0d cyc%0d addr=%0d got data=%h busy=%b want %h %b",
                        k, n, rda[k*5 +: 5], a_rd_data[k*32 +: 32], a_rd_busy[k],
                        exp_rd(rda[k*5 +: 5]), exp_busy(rda[k*5 +: 5]));
            end
         end
         ec = exp_cnt();
         checks++;
         if (int'(a_busy_cnt) != ec || a_rsv_full !== (ec == 31)) begin
            errors++;
            $display("FAIL rand_cnt cyc%0d got cnt=%0d full=%b want %0d %b",
                     n, a_busy_cnt, a_rsv_full, ec, (ec == 31));
         end
         a_tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_bypass();
      test_multiport();
      test_scoreboard();
      test_full();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
